// File: rtl/sha256_cme_pipe_ctrl_if.sv
// Job/result handshake bundle for the CME pipeline sequencing controller.
// The master side is the job source and result sink. The slave side is the controller.
interface sha256_cme_pipe_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             start;
    logic             abort;
    logic [31:0]      nonce_start;
    logic [31:0]      nonce_end;
    logic             busy;
    logic             done;
    logic             stage_we;
    logic             nonce_valid;
    logic [31:0]      nonce_out;
    logic             res_valid;
    logic [31:0]      res_nonce;
    logic             res_ready;
    logic [CNT_W-1:0] inflight;

    modport master (
        output start, abort, nonce_start, nonce_end, res_ready,
        input  busy, done, stage_we, nonce_valid, nonce_out,
               res_valid, res_nonce, inflight
    );

    modport slave (
        input  start, abort, nonce_start, nonce_end, res_ready,
        output busy, done, stage_we, nonce_valid, nonce_out,
               res_valid, res_nonce, inflight
    );
endinterface

// File: rtl/sha256_cme_pipe_ctrl.sv
// Sequencing controller for the double-SHA256 compact message expander pipeline.
// It issues one nonce per cycle into stage 0 and drives the shared stage write enable.
// The whole pipeline freezes while the last-stage result is refused.
// Each slot carries its nonce tag, and a done pulse follows once the pipeline has drained.
module sha256_cme_pipe_ctrl #(
    parameter int PIPE_DEPTH = 64,
    parameter int CNT_W      = 7
) (
    input logic                  CLK,
    input logic                  RST,
    sha256_cme_pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PIPE_DEPTH-1:0] vld_q;
    logic [31:0]           tag_q [PIPE_DEPTH];
    logic [31:0]           cur_q;
    logic [31:0]           rem_q;
    logic [CNT_W-1:0]      inflight_q;

    logic active;
    logic stall;
    logic stage_we;
    logic nonce_valid;
    logic consume;
    logic abort_hit;
    logic accept;

    assign active      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign stall       = vld_q[PIPE_DEPTH-1] && !bus.res_ready;
    assign stage_we    = active && !stall;
    assign nonce_valid = (state_q == S_ISSUE) && stage_we;
    // Shifting the last slot out while it is valid is exactly a consumed result.
    assign consume     = stage_we && vld_q[PIPE_DEPTH-1];
    assign abort_hit   = bus.abort && (state_q != S_IDLE);
    assign accept      = (state_q == S_IDLE) && bus.start && !bus.abort;

    // Next-state logic for the job sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: begin
                if (bus.abort)                        state_d = S_IDLE;
                else if (nonce_valid && rem_q == '0)  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.abort)        state_d = S_IDLE;
                else if (vld_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Nonce cursor and remaining count. rem counts the nonces still to issue after the current one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_q <= '0;
            rem_q <= '0;
        end else if (accept) begin
            cur_q <= bus.nonce_start;
            rem_q <= bus.nonce_end - bus.nonce_start;
        end else if (nonce_valid) begin
            cur_q <= cur_q + 32'd1;
            rem_q <= rem_q - 32'd1;
        end
    end

    // Slot valid chain and occupancy count. Both advance only with stage_we, and an abort flushes them.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else if (abort_hit) begin
            vld_q      <= '0;
            inflight_q <= '0;
        end else if (stage_we) begin
            vld_q <= {vld_q[PIPE_DEPTH-2:0], nonce_valid};
            case ({nonce_valid, consume})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Nonce tags shift in lock-step with the valid chain.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < PIPE_DEPTH; i++) tag_q[i] <= '0;
        end else if (stage_we) begin
            tag_q[0] <= cur_q;
            for (int i = 1; i < PIPE_DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.stage_we    = stage_we;
    assign bus.nonce_valid = nonce_valid;
    assign bus.nonce_out   = cur_q;
    assign bus.res_valid   = vld_q[PIPE_DEPTH-1];
    assign bus.res_nonce   = tag_q[PIPE_DEPTH-1];
    assign bus.inflight    = inflight_q;
endmodule

// File: tb/tb_sha256_cme_pipe_ctrl.sv
// Scoreboard bench for sha256_cme_pipe_ctrl. Jobs push their expected nonce sequence.
// A monitor pops and compares on every accepted result.
module tb_sha256_cme_pipe_ctrl;
    localparam int D  = 64;
    localparam int CW = 7;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    sha256_cme_pipe_ctrl_if #(.CNT_W(CW)) bus ();

    sha256_cme_pipe_ctrl #(.PIPE_DEPTH(D), .CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          max_infl = 0;
    logic [31:0] exp_q [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_nonce = '0;

    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    function void chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Monitor: scores accepted results, stall behaviour, done pulses and peak occupancy.
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            if (bus.done) done_cnt++;
            if (int'(bus.inflight) > max_infl) max_infl = int'(bus.inflight);
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got %0h, expected no result", bus.res_nonce);
                end else begin
                    chk("res_nonce", bus.res_nonce, exp_q.pop_front());
                end
                prev_stall = 1'b0;
            end else if (bus.res_valid && !bus.res_ready) begin
                chk("stall_we", bus.stage_we, 0);
                if (prev_stall) chk("stall_hold", bus.res_nonce, prev_nonce);
                prev_stall = 1'b1;
                prev_nonce = bus.res_nonce;
            end else begin
                prev_stall = 1'b0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic start_job(input logic [31:0] s, input logic [31:0] e);
        logic [31:0] n;
        n = s;
        forever begin
            exp_q.push_back(n);
            if (n == e) break;
            n = n + 32'd1;
        end
        @(posedge CLK); #1;
        bus.nonce_start = s;
        bus.nonce_end   = e;
        bus.start       = 1'b1;
        @(posedge CLK); #1;
        bus.start       = 1'b0;
    endtask

    // which: 0 = nonce_valid, 1 = res_valid, 2 = done
    task automatic wait_for(input int which, input int budget, output int at);
        bit hit;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            case (which)
                0:       hit = bus.nonce_valid;
                1:       hit = bus.res_valid;
                default: hit = bus.done;
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            $display("FAIL timeout_wait_%0d: got no event, expected one within %0d cycles", which, budget);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_stage_we"}, bus.stage_we, 0);
        chk({tag, "_nonce_valid"}, bus.nonce_valid, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_nonce_out"}, bus.nonce_out, 0);
        chk({tag, "_res_nonce"}, bus.res_nonce, 0);
        chk({tag, "_inflight"}, bus.inflight, 0);
    endtask

    initial begin
        int t_iss, t_res, t_done, c0, d0, k;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.nonce_start = '0;
        bus.nonce_end = '0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge CLK);
        #1 chk_all_zero("reset");
        @(negedge CLK) RST = 1'b1;

        // Single nonce: latency 64, done two cycles after the result
        d0 = done_cnt;
        start_job(32'h10, 32'h10);
        wait_for(0, 10, t_iss);
        @(negedge CLK);
        chk("single_issue_once", bus.nonce_valid, 0);
        wait_for(1, 100, t_res);
        chk("latency", t_res - t_iss, 64);
        wait_for(2, 10, t_done);
        chk("done_delay", t_done - t_res, 2);
        @(negedge CLK);
        chk("busy_after_done", bus.busy, 0);
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_q_empty", exp_q.size(), 0);

        // Range 0x100..0x1FF: full throughput, inflight peaks at 64
        d0 = done_cnt;
        max_infl = 0;
        start_job(32'h100, 32'h1FF);
        wait_for(2, 600, t_done);
        chk("range_max_inflight", max_infl, 64);
        chk("range_done_cnt", done_cnt - d0, 1);
        chk("range_q_empty", exp_q.size(), 0);

        // Wrap through 0xFFFFFFFF
        d0 = done_cnt;
        start_job(32'hFFFF_FFFE, 32'h0000_0001);
        wait_for(2, 200, t_done);
        chk("wrap_done_cnt", done_cnt - d0, 1);
        chk("wrap_q_empty", exp_q.size(), 0);

        // Back-pressure: three 5-cycle stalls while results flow, done delayed by 15 cycles
        d0 = done_cnt;
        start_job(32'h5000, 32'h5063);
        wait_for(0, 10, c0);
        t_done = -1;
        for (int i = 0; i < 300 && t_done < 0; i++) begin
            @(posedge CLK); #1;
            k = cyc - c0;
            bus.res_ready = !((k >= 70 && k < 75) || (k >= 100 && k < 105) || (k >= 140 && k < 145));
            @(negedge CLK);
            if (bus.done) t_done = cyc;
        end
        bus.res_ready = 1'b1;
        if (t_done < 0) begin
            n_chk++;
            $display("FAIL bp_timeout: got no done, expected done at offset 180");
        end else begin
            chk("bp_done_offset", t_done - c0, 180);
        end
        chk("bp_done_cnt", done_cnt - d0, 1);
        chk("bp_q_empty", exp_q.size(), 0);

        // Abort after 30 issues
        d0 = done_cnt;
        start_job(32'h2000, 32'h20FF);
        wait_for(0, 10, c0);
        repeat (30) @(posedge CLK);
        #1 bus.abort = 1'b1;
        @(posedge CLK); #1;
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_inflight", bus.inflight, 0);
        chk("abort_stage_we", bus.stage_we, 0);
        exp_q.delete();
        repeat (80) @(negedge CLK);
        chk("abort_no_done", done_cnt - d0, 0);

        // start and abort together in IDLE
        @(posedge CLK); #1;
        bus.nonce_start = 32'h7000;
        bus.nonce_end   = 32'h7000;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", bus.busy, 0);

        // Clean job after abort, with a start while busy that must be ignored
        d0 = done_cnt;
        start_job(32'h3000, 32'h3003);
        bus.nonce_start = 32'h9000;
        bus.nonce_end   = 32'h9000;
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        wait_for(2, 200, t_done);
        chk("rerun_done_cnt", done_cnt - d0, 1);
        chk("rerun_q_empty", exp_q.size(), 0);
        repeat (5) @(negedge CLK);
        chk("ignored_start_idle", bus.busy, 0);

        // Reset during DRAIN clears outputs immediately, with no done pulse afterwards
        d0 = done_cnt;
        start_job(32'h4000, 32'h4004);
        wait_for(0, 10, c0);
        repeat (10) @(posedge CLK);
        #2 RST = 1'b0;
        #1 chk_all_zero("async_rst");
        exp_q.delete();
        @(negedge CLK) RST = 1'b1;
        repeat (100) @(negedge CLK);
        chk("rst_no_done", done_cnt - d0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sha256_cme_pipe_ctrl.md
Name: sha256_cme_pipe_ctrl

Overview:
- Sequencing controller for the double-SHA256 Compact Message Expander pipeline.
- Accepts a nonce-range job and issues one nonce per cycle into stage 0.
- Drives the common write enable of every stage's block memory, stalling the whole pipeline on output back-pressure.
- Tags each in-flight slot with its nonce and signals job completion once the pipeline has drained.

Parameters:
PIPE_DEPTH, 64, number of pipeline stages between issue and result (stage memories sharing stage_we)
CNT_W, 7, width of in-flight counter (must satisfy 2^CNT_W > PIPE_DEPTH)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous, active-low reset
start  in  1  one-cycle job request, honoured only in IDLE
abort  in  1  flush request, honoured in any non-IDLE state
nonce_start  in  32  first nonce of range, sampled on accepted start
nonce_end  in  32  last nonce of range (inclusive), sampled on accepted start
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last result has been accepted
stage_we  out  1  common write_en to all stage memories; pipeline advances only when 1
nonce_valid  out  1  stage-0 input holds a new nonce this cycle
nonce_out  out  32  nonce presented to stage 0
res_valid  out  1  last stage holds a valid result
res_nonce  out  32  nonce tag of the last-stage result
res_ready  in  1  downstream accepts the result
inflight  out  CNT_W  count of valid slots in the pipeline

Behaviour:
- Reset (RST=0, async): state IDLE; valid shift register vld[PIPE_DEPTH-1:0]=0; tag registers=0; nonce counter=0; remaining count=0. Outputs busy, done, stage_we, nonce_valid, res_valid = 0; nonce_out, res_nonce, inflight = 0. Reset mid-job discards all work with no done pulse.
- States:
  - IDLE -> ISSUE on start && !abort. Load cur=nonce_start and rem=(nonce_end-nonce_start) mod 2^32 (rem+1 nonces to issue). nonce_end < nonce_start wraps through 0xFFFFFFFF. nonce_end==nonce_start gives one nonce.
  - ISSUE -> DRAIN when the last nonce is issued (rem==0 and issue fires).
  - DRAIN -> DONE when vld==0.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
  - Any non-IDLE state -> IDLE on abort: vld cleared the next edge, no done pulse, results in flight are dropped. abort in IDLE is ignored.
- start outside IDLE is ignored.
- Stall rule: stall = vld[PIPE_DEPTH-1] && !res_ready. stage_we = (ISSUE or DRAIN) && !stall. stage_we is 0 in IDLE and DONE.
- Issue: nonce_valid = (state==ISSUE) && stage_we; nonce_out = cur. On issue, cur <= cur+1 (mod 2^32, wraps 0xFFFFFFFF->0) and rem <= rem-1.
- Shift: when stage_we=1, vld <= {vld[PIPE_DEPTH-2:0], nonce_valid} and the tags shift in step, with tag[0] <= nonce_out. When stage_we=0, vld and tags hold.
- res_valid = vld[PIPE_DEPTH-1]; res_nonce = tag[PIPE_DEPTH-1]. A result is consumed on res_valid && res_ready. res_valid stays asserted with a stable res_nonce until consumed.
- Latency: a nonce issued in cycle t with no stalls gives res_valid in cycle t+PIPE_DEPTH. Throughput is one result per cycle.
- inflight = popcount(vld), registered alongside vld: +1 on issue, -1 on consumption, net 0 on both in the same cycle.
- A result slot that is shifted out is consumed by definition, since shifting requires !stall.

Test Plan:
- Single nonce, PIPE_DEPTH=64, nonce_start=nonce_end=0x00000010, res_ready=1 -> nonce_valid one cycle; res_valid exactly 64 cycles later with res_nonce=0x10; done pulses 2 cycles after that result; busy falls with done.
- Range 0x100..0x1FF, res_ready=1 -> 256 consecutive results 0x100..0x1FF; inflight saturates at 64; done once.
- Wrap range 0xFFFFFFFE..0x00000001 -> results FFFFFFFE, FFFFFFFF, 00000000, 00000001 in order.
- Back-pressure: range of 100, res_ready toggled low for 5 cycles at random points -> stage_we=0 and res_nonce stable during each stall; no nonce lost or duplicated; total latency grows by the stall cycles.
- Abort after 30 issues -> next cycle state IDLE, vld=0, inflight=0, no done; a new start afterwards runs cleanly. start while busy -> ignored; start and abort together in IDLE -> stays IDLE.
- Assert RST low mid-DRAIN -> all outputs 0 immediately (asynchronously); no done after release.
